// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// byte-lane identifiers and the wait-state counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;
    localparam int   LANE_W  = 8;
    localparam int   WAIT_W  = 3;

    // Memory is word addressed; bit 0 of a byte address only picks the lane.
    function automatic logic [15:0] word_addr(input logic [15:0] byte_addr);
        return {1'b0, byte_addr[15:1]};
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper: extracts and extends a lane for byte loads,
// and splices a new byte into a word for read-modify-write byte stores.
import lsu_pkg::*;

module lsu_byte_lane #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] word,
    input  logic              lane,
    input  logic              sign_ext,
    input  logic [LANE_W-1:0] byte_in,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [LANE_W-1:0] sel_byte;

    assign sel_byte  = (lane == LANE_HI) ? word[LANE_W +: LANE_W] : word[0 +: LANE_W];
    assign load_data = sign_ext ? {{(DATA_W-LANE_W){sel_byte[LANE_W-1]}}, sel_byte}
                                : {{(DATA_W-LANE_W){1'b0}}, sel_byte};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / LANE_W; gi++) begin : g_lane
            assign merged[gi*LANE_W +: LANE_W] =
                (lane == 1'(gi)) ? byte_in : word[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, level-sensitive strobes
// with held address/data, byte stores done as read-modify-write.
import lsu_pkg::*;

module load_store_unit #(
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [15:0]       mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);

    lsu_state_t        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              write_reg, byte_reg, signed_reg, lane_reg;
    logic [LANE_W-1:0] wbyte_reg;
    logic [15:0]       mem_address_reg;
    logic [DATA_W-1:0] mem_writedata_reg;
    logic [DATA_W-1:0] resp_rdata_reg;
    logic              resp_error_reg;

    logic              req_fire;
    logic              req_err;
    logic              read_last;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merge;

    assign req_fire  = req_valid && req_ready;
    assign req_err   = (!req_byte && req_addr[0]) ||
                       ({16'd0, word_addr(req_addr)} >= 32'(MEM_DEPTH));
    assign read_last = (state_reg == ST_READ) && (wait_cnt_reg == '0);

    lsu_byte_lane #(
        .DATA_W (DATA_W)
    ) u_byte_lane (
        .word      (mem_readData),
        .lane      (lane_reg),
        .sign_ext  (signed_reg),
        .byte_in   (wbyte_reg),
        .load_data (lane_load),
        .merged    (lane_merge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_err) begin
                        state_next = ST_RESP;
                    end else if (req_write && !req_byte) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (wait_cnt_reg == '0) begin
                    state_next = write_reg ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes and handshakes are pure state decodes, never fed from req_*.
    always_comb begin
        req_ready    = (state_reg == ST_IDLE);
        mem_memRead  = (state_reg == ST_READ);
        mem_memWrite = (state_reg == ST_WRITE);
        resp_valid   = (state_reg == ST_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg      <= '0;
            write_reg         <= 1'b0;
            byte_reg          <= 1'b0;
            signed_reg        <= 1'b0;
            lane_reg          <= LANE_LO;
            wbyte_reg         <= '0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            resp_rdata_reg    <= '0;
            resp_error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_fire) begin
                        write_reg      <= req_write;
                        byte_reg       <= req_byte;
                        signed_reg     <= req_signed;
                        lane_reg       <= req_addr[0];
                        wbyte_reg      <= req_wdata[LANE_W-1:0];
                        wait_cnt_reg   <= WAIT_W'(WAIT_STATES);
                        resp_error_reg <= req_err;
                        resp_rdata_reg <= '0;
                        // Rejected requests leave the memory-side registers untouched.
                        if (!req_err) begin
                            mem_address_reg <= word_addr(req_addr);
                            if (req_write && !req_byte) begin
                                mem_writedata_reg <= req_wdata;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (!read_last) begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end else if (write_reg) begin
                        mem_writedata_reg <= lane_merge;
                    end else begin
                        resp_rdata_reg <= byte_reg ? lane_load : mem_readData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_address   = mem_address_reg;
    assign mem_writeData = mem_writedata_reg;
    assign resp_rdata    = resp_rdata_reg;
    assign resp_error    = resp_error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory;
// expectations come from a shadow memory kept by the stimulus side.
`timescale 1ns/1ps

module tb_load_store_unit;

    localparam int N     = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          start;
        int          lat;
        int          nrd;
        int          nwr;
        logic [15:0] waddr;
        logic [15:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic [15:0] mem_address;
    logic [15:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [15:0] mem_readData;

    logic [15:0] mem_model [0:DEPTH-1];
    logic [15:0] ref_mem   [0:DEPTH-1];
    exp_t        sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int nrd = 0;
    int nwr = 0;
    int wr_total = 0;
    int resp_total = 0;

    load_store_unit #(
        .DATA_W      (16),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_byte      (req_byte),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memWrite  (mem_memWrite),
        .mem_memRead   (mem_memRead),
        .mem_readData  (mem_readData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_memWrite) mem_model[mem_address[9:0]] <= mem_writeData;
    end

    assign mem_readData = mem_memRead ? mem_model[mem_address[9:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Output-side monitor: strobe accounting and scoreboard pops.
    always @(negedge clk) begin
        if (reset) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (mem_memRead || mem_memWrite)
                check("strobe_excl", 32'(mem_memRead && mem_memWrite), 0);
            if (mem_memRead) begin
                nrd++;
                if (sb.size() > 0) check("rd_addr", mem_address, sb[0].waddr);
            end
            if (mem_memWrite) begin
                nwr++;
                wr_total++;
                if (sb.size() > 0) begin
                    check("wr_addr", mem_address, sb[0].waddr);
                    check("wr_data", mem_writeData, sb[0].wdata);
                end
            end
            if (resp_valid) begin
                resp_total++;
                check("resp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_lat", cyc - e.start, e.lat);
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_error", resp_error, e.err);
                    check("rd_cycles", nrd, e.nrd);
                    check("wr_cycles", nwr, e.nwr);
                    if (!e.err) check("addr_hold", mem_address, e.waddr);
                end
                nrd = 0;
                nwr = 0;
            end
        end
    end

    // Expected outcome of one request; updates the shadow memory for stores.
    function automatic exp_t build_exp(input logic w, input logic b, input logic s,
                                       input logic [15:0] a, input logic [15:0] d);
        exp_t        e;
        logic [15:0] old_w;
        logic [7:0]  sel;
        e.err   = (!b && a[0]) || (int'(a[15:1]) >= DEPTH);
        e.waddr = {1'b0, a[15:1]};
        e.rdata = 16'h0;
        e.wdata = 16'h0;
        e.nrd   = 0;
        e.nwr   = 0;
        e.start = 0;
        old_w   = e.err ? 16'h0 : ref_mem[a[10:1]];
        sel     = a[0] ? old_w[15:8] : old_w[7:0];
        if (e.err) begin
            e.lat = 1;
        end else if (w && !b) begin
            e.lat = 2;
            e.nwr = 1;
            e.wdata = d;
            ref_mem[a[10:1]] = d;
        end else if (w) begin
            e.lat = 3 + N;
            e.nrd = N + 1;
            e.nwr = 1;
            e.wdata = a[0] ? {d[7:0], old_w[7:0]} : {old_w[15:8], d[7:0]};
            ref_mem[a[10:1]] = e.wdata;
        end else begin
            e.lat = 2 + N;
            e.nrd = N + 1;
            if (b) e.rdata = s ? {{8{sel[7]}}, sel} : {8'h00, sel};
            else   e.rdata = old_w;
        end
        return e;
    endfunction

    task automatic drain();
        int left;
        left = 40;
        while (sb.size() != 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        check("resp_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_req(input logic w, input logic b, input logic s,
                          input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e = build_exp(w, b, s, a, d);
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        e.start = cyc;
        sb.push_back(e);
        $display("txn w=%0d b=%0d s=%0d addr=%04h wdata=%04h exp_rdata=%04h exp_err=%0d",
                 w, b, s, a, d, e.rdata, e.err);
        req_valid  = 1'b1;
        req_write  = w;
        req_byte   = b;
        req_signed = s;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_rvalid"}, resp_valid, 0);
        check({tag, "_rerr"}, resp_error, 0);
        check({tag, "_rdata"}, resp_rdata, 0);
        check({tag, "_mrd"}, mem_memRead, 0);
        check({tag, "_mwr"}, mem_memWrite, 0);
        check({tag, "_maddr"}, mem_address, 0);
        check({tag, "_mwdata"}, mem_writeData, 0);
    endtask

    initial begin
        int          wr_before, resp_before;
        exp_t        e;
        logic [15:0] a, d;
        int          r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;

        repeat (3) @(negedge clk);
        check_idle_outputs("rst_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_done");

        // Preload a small window so every later load reads a defined word.
        for (int i = 0; i < 32; i++) do_req(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'(i * 16'h0101 + 16'h0F00));
        do_req(1'b1, 1'b0, 1'b0, 16'h07FE, 16'h5A5A);

        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);

        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80F3);
        do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        do_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        do_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);

        do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234);
        do_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB);
        do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
        do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'hFFCD);
        do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);

        do_req(1'b0, 1'b1, 1'b0, 16'h07FF, 16'h0000);
        do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
        do_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h1111);
        do_req(1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000);
        do_req(1'b1, 1'b1, 1'b0, 16'h0801, 16'h0022);

        // A request offered while busy must be ignored entirely.
        resp_before = resp_total;
        e = build_exp(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        e.start = cyc;
        sb.push_back(e);
        $display("txn busy-probe load addr=0010 exp_rdata=%04h", e.rdata);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ready_busy", req_ready, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hDEAD;
        @(posedge clk);
        #1 req_valid = 1'b0; req_write = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("busy_one_resp", resp_total - resp_before, 1);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);

        // Reset in the read phase of a byte store: no write, no response.
        wr_before   = wr_total;
        resp_before = resp_total;
        @(negedge clk);
        $display("txn reset-probe byte store addr=0021 wdata=0077");
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_addr = 16'h0021; req_wdata = 16'h0077;
        @(posedge clk);
        #1 req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        check("rmw_in_read", mem_memRead, 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_no_write", wr_total - wr_before, 0);
        check("rst_no_resp", resp_total - resp_before, 0);
        check("rst_mem_kept", mem_model[16], ref_mem[16]);
        do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            a = 16'($urandom_range(0, 63));
            if (r == 0) a = a + 16'h0800;
            d = 16'($urandom);
            do_req(r < 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory port. Accepts one load or store at a time from the execute stage over a valid/ready handshake, converts byte addresses to word addresses, drives the `Data_Memory` level-sensitive read/write strobes with stable address and data, and returns load data (word, or sign/zero-extended byte) as a one-cycle response pulse. Byte stores are done as read-modify-write on the 16-bit memory word.

## Interface
- `DATA_W`, 16, memory word width; fixed at 16 in this revision.
- `MEM_DEPTH`, 1024, number of memory words; word addresses `>= MEM_DEPTH` are errors.
- `WAIT_STATES`, 0, extra cycles `mem_memRead` is held before read data is captured (0..7).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept; handshake when both are high on a rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = 16-bit word access.
- `req_signed`  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  16  byte address; `[0]` selects the lane (0 = bits 7:0, 1 = bits 15:8).
- `req_wdata`  in  16  store data; byte stores use `[7:0]`.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  16  load result; 0 for stores and errors.
- `resp_error`  out  1  qualified by `resp_valid`: misaligned word access or out-of-range address.
- `mem_address`  out  16  word address, `req_addr >> 1`.
- `mem_writeData`  out  16  word to write.
- `mem_memWrite`  out  1  write strobe.
- `mem_memRead`  out  1  read strobe.
- `mem_readData`  in  16  memory read data, valid while `mem_memRead` is high.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready` = 1. All request fields are registered on the handshake.
  - Error check: `!req_byte && req_addr[0]`, or `(req_addr>>1) >= MEM_DEPTH`.
  - On error, go to RESP with `resp_error` = 1 and no memory strobe.
  - Otherwise, go to READ for a load or byte store, and to WRITE for a word store.
- READ:
  - `mem_memRead` = 1 for `WAIT_STATES+1` cycles, counted by a 3-bit down-counter.
  - On the last cycle, capture `mem_readData`.
  - Load: go to RESP. Byte store: go to WRITE.
- WRITE:
  - `mem_memWrite` = 1 for exactly one cycle.
  - `mem_writeData` is `req_wdata` for a word store, or the captured word with the selected lane replaced by `req_wdata[7:0]` for a byte store.
  - Go to RESP.
- RESP: `resp_valid` = 1 for one cycle, then go to IDLE.
- Load result:
  - Word load: the captured word.
  - Byte load: the selected lane, sign- or zero-extended to 16 bits.
- Strobes:
  - `mem_memRead` and `mem_memWrite` are never high in the same cycle.
  - Both come directly from state flops; no combinational path from `req_*`.
- Hold rules:
  - `mem_address` and `mem_writeData` are registered and stay constant from the first strobe cycle through RESP.
  - In IDLE they hold their last values.

## Timing
- The handshake is at cycle 0; N = `WAIT_STATES`.
- Word load: `mem_memRead` high in cycles 1..1+N; `resp_valid` in cycle 2+N.
- Word store: `mem_memWrite` high in cycle 1; `resp_valid` in cycle 2.
- Byte load: same timing as a word load.
- Byte store: `mem_memRead` high in cycles 1..1+N, `mem_memWrite` in cycle 2+N, `resp_valid` in cycle 3+N.
- Error: `resp_valid` and `resp_error` in cycle 1.
- Next request: `req_ready` returns in the cycle after RESP. Back-to-back word stores therefore complete one per 3 cycles.
- `req_valid` while `req_ready` = 0 is ignored; the request is not captured.
- Reset values (asynchronous, mid-operation included):
  - State IDLE; `req_ready` = 1.
  - `resp_valid`, `resp_error`, `mem_memRead`, `mem_memWrite` = 0.
  - `resp_rdata`, `mem_address`, `mem_writeData` = 0.
- Reset during READ of a byte store leaves memory unmodified. No response is issued for an abandoned request.

## Structure
- Package `lsu_pkg` holds:
  - the state enum `lsu_state_t`;
  - lane constants `LANE_LO`/`LANE_HI`;
  - the `WAIT_W` counter width.
- Sub-module `lsu_byte_lane` is combinational:
  - Extract path: lane select plus sign/zero extension, for loads.
  - Merge path: lane replace, for byte stores.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store then load, N=0:
  - Store `addr=0x0010`, `wdata=0xBEEF` → `mem_address=0x0008`, `memWrite` in cycle 1, `resp_valid` in cycle 2.
  - Load `0x0010` → `resp_rdata=0xBEEF` in cycle 2.
- Byte loads, word 0x0008 = `0x80F3`, N=2:
  - Signed load of `0x0011` → `0xFF80` in cycle 4.
  - Unsigned load of `0x0010` → `0x00F3`.
- Byte store RMW: word = `0x1234`; store byte `0xAB` to `0x0011` → `mem_writeData=0xAB34` in cycle 2+N; a later load returns `0xAB34`.
- Errors:
  - Word load at `0x0003` → `resp_error=1`, `resp_rdata=0` in cycle 1, no strobe asserted.
  - Address `0x0800` with `MEM_DEPTH=1024` → same result.
- Busy request: pulse `req_valid` during READ → `req_ready=0`, request ignored, exactly one `resp_valid`.
- Reset mid-RMW: assert `reset` in the READ cycle of a byte store → outputs zero immediately, `memWrite` never asserted, memory word unchanged.
